// File: rtl/kinrow_game_ctrl_if.sv
// ============================================================================
// kinrow_game_ctrl_if : move handshake and board/status bundle for the game ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface kinrow_game_ctrl_if #(
    parameter int N = 3
);
    localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;

    logic              start;
    logic              p1_first;
    logic              move_valid;
    logic [CW-1:0]     move_row;
    logic [CW-1:0]     move_col;
    logic              move_ready;
    logic              move_err;
    logic              turn;
    logic [2*N*N-1:0]  board;
    logic [1:0]        game_state;
    logic [1:0]        winner;

    // Front end / player input side
    modport master (
        output start, p1_first, move_valid, move_row, move_col,
        input  move_ready, move_err, turn, board, game_state, winner
    );

    // Game controller side
    modport slave (
        input  start, p1_first, move_valid, move_row, move_col,
        output move_ready, move_err, turn, board, game_state, winner
    );
endinterface

`default_nettype wire

// File: rtl/kinrow_game_ctrl.sv
// ============================================================================
// kinrow_game_ctrl : N x N, K-in-a-row two-player controller with line-scan check
// Rev 1.0
// ============================================================================
`default_nettype none

module kinrow_game_ctrl #(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic               clk,
    input  logic               reset,
    kinrow_game_ctrl_if.slave  bus
);

    localparam int CW   = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int IW   = $clog2(N*N);
    localparam int CNTW = $clog2(N*N+1);
    localparam int RW   = $clog2(K+1);

    localparam logic [CW:0]        C_N     = (CW+1)'(N);
    localparam logic [CNTW-1:0]    C_CELLS = CNTW'(N*N);
    localparam logic [RW-1:0]      C_K     = RW'(K);
    localparam logic [RW-1:0]      C_RUN1  = RW'(1);
    localparam logic signed [CW:0] C_Z     = '0;
    localparam logic signed [CW:0] C_P1    = (CW+1)'(1);
    localparam logic signed [CW:0] C_M1    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q,  state_d;
    logic [N*N-1:0][1:0]    board_q,  board_d;
    logic [CNTW-1:0]        count_q,  count_d;
    logic                   turn_q,   turn_d;
    logic [1:0]             winner_q, winner_d;
    logic                   err_q,    err_d;
    logic signed [CW:0]     mrow_q,   mrow_d;
    logic signed [CW:0]     mcol_q,   mcol_d;
    logic signed [CW:0]     crow_q,   crow_d;
    logic signed [CW:0]     ccol_q,   ccol_d;
    logic [1:0]             player_q, player_d;
    logic [1:0]             dir_q,    dir_d;
    logic                   neg_q,    neg_d;
    logic [RW-1:0]          run_q,    run_d;

    // Direction order: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal
    function automatic logic signed [CW:0] step_r(input logic [1:0] d);
        return (d == 2'd0) ? C_Z : C_P1;
    endfunction

    function automatic logic signed [CW:0] step_c(input logic [1:0] d);
        case (d)
            2'd0:    return C_P1;
            2'd1:    return C_Z;
            2'd2:    return C_P1;
            default: return C_M1;
        endcase
    endfunction

    function automatic logic in_bounds(input logic signed [CW:0] r, input logic signed [CW:0] c);
        return !r[CW] && !c[CW] &&
               ({1'b0, r[CW-1:0]} < C_N) && ({1'b0, c[CW-1:0]} < C_N);
    endfunction

    function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) * IW'(N) + IW'(c);
    endfunction

    logic                w_legal_pos;
    logic [IW-1:0]       w_move_idx;
    logic [IW-1:0]       w_scan_idx;
    logic                w_inb;
    logic                w_match;
    logic [RW-1:0]       w_run_inc;
    logic [1:0]          w_dir_nx;
    logic signed [CW:0]  w_sr;
    logic signed [CW:0]  w_sc;

    assign w_legal_pos = ({1'b0, bus.move_row} < C_N) && ({1'b0, bus.move_col} < C_N);
    assign w_move_idx  = cell_idx(bus.move_row, bus.move_col);
    // Index is only consumed once the bounds check has passed
    assign w_inb       = in_bounds(crow_q, ccol_q);
    assign w_scan_idx  = cell_idx(crow_q[CW-1:0], ccol_q[CW-1:0]);
    assign w_match     = w_inb && (board_q[w_scan_idx] == player_q);
    assign w_run_inc   = run_q + C_RUN1;
    assign w_dir_nx    = dir_q + 2'd1;
    assign w_sr        = step_r(dir_q);
    assign w_sc        = step_c(dir_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            count_q  <= '0;
            turn_q   <= 1'b0;
            winner_q <= 2'b00;
            err_q    <= 1'b0;
            mrow_q   <= '0;
            mcol_q   <= '0;
            crow_q   <= '0;
            ccol_q   <= '0;
            player_q <= 2'b00;
            dir_q    <= 2'd0;
            neg_q    <= 1'b0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            count_q  <= count_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            err_q    <= err_d;
            mrow_q   <= mrow_d;
            mcol_q   <= mcol_d;
            crow_q   <= crow_d;
            ccol_q   <= ccol_d;
            player_q <= player_d;
            dir_q    <= dir_d;
            neg_q    <= neg_d;
            run_q    <= run_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        count_d  = count_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        err_d    = 1'b0;
        mrow_d   = mrow_q;
        mcol_d   = mcol_q;
        crow_d   = crow_q;
        ccol_d   = ccol_q;
        player_d = player_q;
        dir_d    = dir_q;
        neg_d    = neg_q;
        run_d    = run_q;

        if (bus.start) begin
            board_d  = '0;
            count_d  = '0;
            winner_d = 2'b00;
            turn_d   = ~bus.p1_first;
            state_d  = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (bus.move_valid) begin
                        if (!w_legal_pos || (board_q[w_move_idx] != 2'b00)) begin
                            err_d = 1'b1;
                        end else begin
                            board_d[w_move_idx] = turn_q ? 2'b10 : 2'b01;
                            count_d  = count_q + CNTW'(1);
                            player_d = turn_q ? 2'b10 : 2'b01;
                            mrow_d   = $signed({1'b0, bus.move_row});
                            mcol_d   = $signed({1'b0, bus.move_col});
                            crow_d   = $signed({1'b0, bus.move_row});
                            ccol_d   = $signed({1'b0, bus.move_col}) + C_P1;
                            dir_d    = 2'd0;
                            neg_d    = 1'b0;
                            run_d    = C_RUN1;
                            state_d  = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        run_d = w_run_inc;
                        if (w_run_inc == C_K) begin
                            winner_d = player_q;
                            state_d  = S_DONE;
                        end else begin
                            crow_d = neg_q ? (crow_q - w_sr) : (crow_q + w_sr);
                            ccol_d = neg_q ? (ccol_q - w_sc) : (ccol_q + w_sc);
                        end
                    end else if (!neg_q) begin
                        neg_d  = 1'b1;
                        crow_d = mrow_q - w_sr;
                        ccol_d = mcol_q - w_sc;
                    end else if (dir_q != 2'd3) begin
                        dir_d  = w_dir_nx;
                        neg_d  = 1'b0;
                        run_d  = C_RUN1;
                        crow_d = mrow_q + step_r(w_dir_nx);
                        ccol_d = mcol_q + step_c(w_dir_nx);
                    end else if (count_q == C_CELLS) begin
                        winner_d = 2'b11;
                        state_d  = S_DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.move_ready = (state_q == S_WAIT);
    assign bus.move_err   = err_q;
    assign bus.turn       = turn_q;
    assign bus.board      = board_q;
    assign bus.winner     = winner_q;
    assign bus.game_state = (state_q == S_IDLE) ? 2'b00 :
                            (state_q == S_DONE) ? 2'b10 : 2'b01;

endmodule

`default_nettype wire

// File: tb/tb_kinrow_game_ctrl.sv
// ============================================================================
// tb_kinrow_game_ctrl : directed bench for 3x3/K=3 and 5x5/K=4 game controllers
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_kinrow_game_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    kinrow_game_ctrl_if #(.N(3)) if3 ();
    kinrow_game_ctrl_if #(.N(5)) if5 ();

    kinrow_game_ctrl #(.N(3), .K(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
    kinrow_game_ctrl #(.N(5), .K(4)) u_dut5 (.clk(clk), .reset(reset), .bus(if5.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start3(input logic p1f);
        if3.start = 1'b1; if3.p1_first = p1f; tick(); if3.start = 1'b0;
    endtask

    task automatic start5(input logic p1f);
        if5.start = 1'b1; if5.p1_first = p1f; tick(); if5.start = 1'b0;
    endtask

    task automatic move3(input logic [1:0] r, input logic [1:0] c, output int lat);
        int t = 0;
        while (!if3.move_ready && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL move3_ready_timeout got ready=0 want ready=1");
        end
        if3.move_valid = 1'b1; if3.move_row = r; if3.move_col = c;
        tick();
        if3.move_valid = 1'b0;
        lat = 0;
        while (!if3.move_ready && if3.game_state != 2'b10 && lat < 100) begin tick(); lat++; end
    endtask

    task automatic move5(input logic [2:0] r, input logic [2:0] c, output int lat);
        int t = 0;
        while (!if5.move_ready && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL move5_ready_timeout got ready=0 want ready=1");
        end
        if5.move_valid = 1'b1; if5.move_row = r; if5.move_col = c;
        tick();
        if5.move_valid = 1'b0;
        lat = 0;
        while (!if5.move_ready && if5.game_state != 2'b10 && lat < 100) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        if3.start = 1'b1; if3.p1_first = 1'b1; if3.move_valid = 1'b1; if3.move_row = 2'd1; if3.move_col = 2'd1;
        if5.start = 1'b1; if5.p1_first = 1'b1; if5.move_valid = 1'b1; if5.move_row = 3'd1; if5.move_col = 3'd1;
        reset = 1'b0;
        tick(); tick();
        n_cmp++; if (if3.board !== 18'h0) begin n_bad++; $display("FAIL rst_board got %h want 0", if3.board); end
        n_cmp++; if (if3.game_state !== 2'b00) begin n_bad++; $display("FAIL rst_state got %b want 00", if3.game_state); end
        n_cmp++; if (if3.winner !== 2'b00) begin n_bad++; $display("FAIL rst_winner got %b want 00", if3.winner); end
        n_cmp++; if (if3.move_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", if3.move_ready); end
        n_cmp++; if (if3.turn !== 1'b0) begin n_bad++; $display("FAIL rst_turn got %b want 0", if3.turn); end
        n_cmp++; if (if3.move_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", if3.move_err); end
        n_cmp++; if (if5.board !== 50'h0 || if5.game_state !== 2'b00) begin
            n_bad++; $display("FAIL rst_n5 got board=%h gs=%b want 0/00", if5.board, if5.game_state); end
        // Release reset with start low: IDLE must ignore the held move request
        if3.start = 1'b0; if5.start = 1'b0; reset = 1'b1;
        tick(); tick();
        n_cmp++; if (if3.board !== 18'h0 || if3.move_ready !== 1'b0 || if3.game_state !== 2'b00) begin
            n_bad++; $display("FAIL idle_ignore got board=%h ready=%b gs=%b want 0/0/00", if3.board, if3.move_ready, if3.game_state); end
        if3.move_valid = 1'b0; if5.move_valid = 1'b0;
    endtask

    task automatic test_first_move();
        int lat;
        start3(1'b1);
        n_cmp++; if (if3.game_state !== 2'b01 || if3.move_ready !== 1'b1 || if3.turn !== 1'b0) begin
            n_bad++; $display("FAIL start_p1 got gs=%b ready=%b turn=%b want 01/1/0", if3.game_state, if3.move_ready, if3.turn); end
        move3(2'd1, 2'd1, lat);
        n_cmp++; if (if3.board !== 18'h00100) begin n_bad++; $display("FAIL center_board got %h want 00100", if3.board); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL center_latency got %0d want 8", lat); end
        n_cmp++; if (if3.move_ready !== 1'b1 || if3.turn !== 1'b1) begin
            n_bad++; $display("FAIL center_turn got ready=%b turn=%b want 1/1", if3.move_ready, if3.turn); end
    endtask

    task automatic test_illegal();
        int lat;
        move3(2'd1, 2'd1, lat);
        n_cmp++; if (if3.move_err !== 1'b1) begin n_bad++; $display("FAIL occ_err got %b want 1", if3.move_err); end
        tick();
        n_cmp++; if (if3.move_err !== 1'b0) begin n_bad++; $display("FAIL occ_err_pulse got %b want 0", if3.move_err); end
        n_cmp++; if (if3.board !== 18'h00100 || if3.turn !== 1'b1 || if3.move_ready !== 1'b1) begin
            n_bad++; $display("FAIL occ_hold got board=%h turn=%b ready=%b want 00100/1/1", if3.board, if3.turn, if3.move_ready); end
        move3(2'd3, 2'd0, lat);
        n_cmp++; if (if3.move_err !== 1'b1) begin n_bad++; $display("FAIL oob_err got %b want 1", if3.move_err); end
        tick();
        n_cmp++; if (if3.move_err !== 1'b0 || if3.board !== 18'h00100 || if3.turn !== 1'b1 || if3.game_state !== 2'b01) begin
            n_bad++; $display("FAIL oob_hold got err=%b board=%h turn=%b gs=%b want 0/00100/1/01",
                              if3.move_err, if3.board, if3.turn, if3.game_state); end
    endtask

    task automatic test_row_win();
        int lat;
        logic [1:0] rs [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        logic [1:0] cs [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        start3(1'b1);
        for (int i = 0; i < 5; i++) move3(rs[i], cs[i], lat);
        n_cmp++; if (if3.board !== 18'h00295) begin n_bad++; $display("FAIL row_board got %h want 00295", if3.board); end
        n_cmp++; if (if3.winner !== 2'b01 || if3.game_state !== 2'b10) begin
            n_bad++; $display("FAIL row_win got winner=%b gs=%b want 01/10", if3.winner, if3.game_state); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL row_early_exit got %0d want 3", lat); end
        if3.move_valid = 1'b1; if3.move_row = 2'd2; if3.move_col = 2'd2;
        tick(); tick(); tick();
        if3.move_valid = 1'b0;
        n_cmp++; if (if3.board !== 18'h00295 || if3.move_err !== 1'b0 || if3.move_ready !== 1'b0 || if3.winner !== 2'b01) begin
            n_bad++; $display("FAIL done_ignore got board=%h err=%b ready=%b winner=%b want 00295/0/0/01",
                              if3.board, if3.move_err, if3.move_ready, if3.winner); end
        start3(1'b1);
        n_cmp++; if (if3.board !== 18'h0 || if3.game_state !== 2'b01 || if3.winner !== 2'b00) begin
            n_bad++; $display("FAIL done_restart got board=%h gs=%b winner=%b want 0/01/00", if3.board, if3.game_state, if3.winner); end
    endtask

    task automatic test_draw();
        int lat;
        logic [1:0] rs [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2};
        logic [1:0] cs [9] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
        start3(1'b1);
        for (int i = 0; i < 8; i++) move3(rs[i], cs[i], lat);
        n_cmp++; if (if3.winner !== 2'b00 || if3.game_state !== 2'b01) begin
            n_bad++; $display("FAIL draw_pre got winner=%b gs=%b want 00/01", if3.winner, if3.game_state); end
        move3(rs[8], cs[8], lat);
        n_cmp++; if (if3.winner !== 2'b11 || if3.game_state !== 2'b10) begin
            n_bad++; $display("FAIL draw_result got winner=%b gs=%b want 11/10", if3.winner, if3.game_state); end
        n_cmp++; if (if3.board !== 18'h16A59) begin n_bad++; $display("FAIL draw_board got %h want 16a59", if3.board); end
    endtask

    task automatic test_n5_two_sided();
        int lat;
        logic [2:0] rs [7] = '{3'd1, 3'd0, 3'd3, 3'd4, 3'd4, 3'd0, 3'd2};
        logic [2:0] cs [7] = '{3'd1, 3'd4, 3'd3, 3'd0, 3'd4, 3'd3, 3'd2};
        logic [49:0] exp5;
        exp5 = '0;
        exp5[2*6  +: 2] = 2'b10;
        exp5[2*18 +: 2] = 2'b10;
        exp5[2*24 +: 2] = 2'b10;
        exp5[2*12 +: 2] = 2'b10;
        exp5[2*4  +: 2] = 2'b01;
        exp5[2*20 +: 2] = 2'b01;
        exp5[2*3  +: 2] = 2'b01;
        start5(1'b0);
        n_cmp++; if (if5.turn !== 1'b1) begin n_bad++; $display("FAIL n5_first_turn got %b want 1", if5.turn); end
        for (int i = 0; i < 7; i++) move5(rs[i], cs[i], lat);
        n_cmp++; if (if5.winner !== 2'b10 || if5.game_state !== 2'b10) begin
            n_bad++; $display("FAIL n5_win got winner=%b gs=%b want 10/10", if5.winner, if5.game_state); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL n5_latency got %0d want 8", lat); end
        n_cmp++; if (if5.board !== exp5) begin n_bad++; $display("FAIL n5_board got %h want %h", if5.board, exp5); end
    endtask

    task automatic test_abort_check();
        int lat;
        logic [2:0] rs [6] = '{3'd1, 3'd0, 3'd3, 3'd4, 3'd4, 3'd0};
        logic [2:0] cs [6] = '{3'd1, 3'd4, 3'd3, 3'd0, 3'd4, 3'd3};
        start5(1'b0);
        for (int i = 0; i < 6; i++) move5(rs[i], cs[i], lat);
        if5.move_valid = 1'b1; if5.move_row = 3'd2; if5.move_col = 3'd2;
        tick();
        if5.move_valid = 1'b0;
        n_cmp++; if (if5.move_ready !== 1'b0) begin n_bad++; $display("FAIL abort_in_check got ready=%b want 0", if5.move_ready); end
        tick(); tick();
        start5(1'b0);
        n_cmp++; if (if5.board !== 50'h0 || if5.winner !== 2'b00 || if5.game_state !== 2'b01 || if5.move_ready !== 1'b1) begin
            n_bad++; $display("FAIL abort_clear got board=%h winner=%b gs=%b ready=%b want 0/00/01/1",
                              if5.board, if5.winner, if5.game_state, if5.move_ready); end
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (if5.winner !== 2'b00 || if5.game_state !== 2'b01 || if5.turn !== 1'b1) begin
            n_bad++; $display("FAIL abort_discard got winner=%b gs=%b turn=%b want 00/01/1", if5.winner, if5.game_state, if5.turn); end
    endtask

    initial begin
        if3.start = 1'b0; if3.p1_first = 1'b0; if3.move_valid = 1'b0; if3.move_row = '0; if3.move_col = '0;
        if5.start = 1'b0; if5.p1_first = 1'b0; if5.move_valid = 1'b0; if5.move_row = '0; if5.move_col = '0;
        test_reset();
        test_first_move();
        test_illegal();
        test_row_win();
        test_draw();
        test_n5_two_sided();
        test_abort_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/kinrow_game_ctrl.md
Name: kinrow_game_ctrl

Overview:
- Parametrised successor to the fixed 3x3 tic-tac-toe chip: N x N board, K-in-a-row win rule, two players.
- Accepts one move per valid/ready handshake, writes the board register, then runs a multi-cycle line-scan FSM through the placed cell to detect a win or a draw.
- Sits between the player-input front end and the board/status display logic.
- Board encoding is unchanged from the 3x3 design, so existing display logic and test vectors extend directly.

Parameters:
- N, 3, board dimension (rows = cols); legal range 3..16.
- K, 3, win length; legal range 2 <= K <= N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- start  in  1  single-cycle pulse: clear board, begin new game.
- p1_first  in  1  sampled on start; 1 = P1 moves first.
- move_valid  in  1  move request.
- move_row  in  CW  row index; CW = max(1, $clog2(N)).
- move_col  in  CW  column index.
- move_ready  out  1  high only in state WAIT_MOVE.
- move_err  out  1  one-cycle pulse when a handshaked move is illegal.
- turn  out  1  0 = P1 to move, 1 = P2 to move.
- board  out  2*N*N  cell idx = row*N+col occupies bits [2*idx+1:2*idx]; 00 empty, 01 P1, 10 P2.
- game_state  out  2  00 idle, 01 playing, 10 done.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
Reset and control priority
- reset=0 at a clock edge: board=0, state IDLE, game_state=00, winner=00, turn=0, move_ready=0, move_err=0, move count=0. Reset overrides everything, including mid-CHECK.
- Priority order: reset > start > move handshake.
- start=1 in any state (including CHECK and DONE): board=0, count=0, winner=00, turn=~p1_first, next state WAIT_MOVE. Any in-progress CHECK is aborted and the pending move result is discarded.

FSM states
- IDLE: game_state=00; moves are ignored (move_ready=0).
- WAIT_MOVE: game_state=01, move_ready=1.
  - A move is accepted when move_valid & move_ready are both high at the edge.
  - Illegal move (row>=N, col>=N, or target cell non-empty): move_err=1 for exactly the next cycle; board, turn and state are unchanged.
  - Legal move: cell <= (turn ? 10 : 01), count++, the coordinates and player are latched, next state CHECK.
  - The board updates on the accepting edge.
- CHECK: game_state=01, move_ready=0.
  - Scans 4 directions in order: horizontal (0,+1), vertical (+1,0), diagonal (+1,+1), anti-diagonal (+1,-1).
  - For each direction: run=1; walk the positive direction, then the negative direction, examining one cell per cycle.
  - Each examined in-bounds cell equal to the latched player gives run++ and the walk continues.
  - An out-of-bounds or non-matching cell costs one cycle and ends that half-walk.
  - When run reaches K: winner = player, state DONE immediately (early exit).
  - After all 4 directions with no win: if count == N*N then winner=11, state DONE; otherwise turn toggles and state returns to WAIT_MOVE.
  - Latency example (N=K=3, empty board, move at (1,1)): 8 CHECK cycles, then WAIT_MOVE.
- DONE: game_state=10; winner and board are held; only start or reset exits.

Arithmetic and widths
- Coordinate steps use signed CW+1-bit arithmetic; bounds are checked before any board index is formed.
- Count width is $clog2(N*N+1).
- move_valid is ignored whenever move_ready=0; no move is queued.

Test Plan:
1. Hold reset=0 for 2 cycles with start=1 and move_valid=1 -> board=0, game_state=00, winner=00, move_ready=0, turn=0.
2. N=K=3: start with p1_first=1; P1 plays (1,1) -> board=18'h00100, move_ready low for exactly 8 cycles, then move_ready=1 and turn=1.
3. Illegal moves, continuing from scenario 2:
   - P2 plays (1,1) -> move_err pulses 1 cycle, board stays 18'h00100, turn stays 1.
   - P2 plays row=3 -> move_err pulses again, no state change.
4. Row win, moves in order (0,0)P1, (1,0)P2, (0,1)P1, (1,1)P2, (0,2)P1:
   - Final board=18'h00295, winner=01, game_state=10.
   - A further move_valid is ignored.
   - start returns to board=0, game_state=01.
5. Draw, moves in order X(0,0), O(0,1), X(0,2), O(1,1), X(1,0), O(2,0), X(2,1), O(1,2), X(2,2):
   - After the 9th CHECK: winner=11, game_state=10.
6. N=5, K=4: P2 occupies (1,1), (3,3), (4,4), then plays (2,2) with P1 moves elsewhere:
   - Result: winner=10 (two-sided walk).
   - Repeat the game, asserting start during the final CHECK -> board=0, winner=00, game_state=01.
